// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings, FSM states and alignment helper for the memory access unit
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_RMW_WRITE = 1'b1
  } mem_state_e;

  // Reserved size is treated as a misalignment so it faults on the same path.
  function automatic logic misaligned(input mem_size_e size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = lo[0];
      SIZE_WORD: misaligned = |lo;
      default:   misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane load extraction/extension and store merge into a read word
module mem_lane_align (
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);
  import mem_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    w_byte   = i_rdata[{i_lane, 3'b000} +: 8];
    w_half   = i_rdata[{i_lane[1], 4'b0000} +: 16];
    w_sext   = 1'b0;
    o_load   = i_rdata;
    o_merged = i_rdata;
    case (mem_size_e'(i_size))
      SIZE_BYTE: begin
        w_sext = ~i_unsigned & w_byte[7];
        o_load = {{24{w_sext}}, w_byte};
        o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SIZE_HALF: begin
        w_sext = ~i_unsigned & w_half[15];
        o_load = {{16{w_sext}}, w_half};
        o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      SIZE_WORD: o_merged = i_wdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - pipeline load/store unit with sub-word read-modify-write and fault detection
module mem_access_unit #(
  parameter int ADDR_BITS = 16
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mmu_read,
  output logic        mmu_write,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_wd,
  input  logic [31:0] mmu_data_i,
  input  logic        mmu_stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall_o,
  output logic        fault
);
  import mem_pkg::*;

  localparam logic [31:0] HI_MASK = ~((32'd1 << ADDR_BITS) - 32'd1);

  mem_state_e  r_state;
  logic [31:0] r_merge;

  logic [31:0] w_merged;
  logic [31:0] w_load_val;
  mem_size_e   w_size;
  logic        w_idle_req;
  logic        w_fault;
  logic        w_go;
  logic        w_load;
  logic        w_wstore;
  logic        w_rmw_rd;
  logic        w_rmw_wr;
  logic        w_access;

  mem_lane_align u_align (
    .i_rdata    (mmu_data_i),
    .i_wdata    (req_wdata),
    .i_lane     (req_addr[1:0]),
    .i_size     (req_size),
    .i_unsigned (req_unsigned),
    .o_merged   (w_merged),
    .o_load     (w_load_val)
  );

  // Outputs are gated by rst_n so a live request cannot leak through while reset is held.
  assign w_size     = mem_size_e'(req_size);
  assign w_idle_req = rst_n && (r_state == ST_IDLE) && req_valid;
  assign w_fault    = w_idle_req && (misaligned(w_size, req_addr[1:0]) || |(req_addr & HI_MASK));
  assign w_go       = w_idle_req && !w_fault;
  assign w_load     = w_go && !req_write;
  assign w_wstore   = w_go && req_write && (w_size == SIZE_WORD);
  assign w_rmw_rd   = w_go && req_write && (w_size != SIZE_WORD);
  assign w_rmw_wr   = rst_n && (r_state == ST_RMW_WRITE);
  assign w_access   = w_go || w_rmw_wr;

  always_comb begin
    mmu_read  = w_load || w_rmw_rd;
    mmu_write = w_wstore || w_rmw_wr;
    mmu_addr  = w_access ? {req_addr[31:2], 2'b00} : 32'd0;
    mmu_wd    = w_rmw_wr ? r_merge : (w_wstore ? req_wdata : 32'd0);
    load_data = w_load ? w_load_val : 32'd0;
    fault     = w_fault;
    stall_o   = w_rmw_rd || (w_access && mmu_stall);
    done      = w_fault || ((w_load || w_wstore || w_rmw_wr) && !mmu_stall);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_merge <= 32'd0;
    end else if (!mmu_stall) begin
      case (r_state)
        ST_IDLE: begin
          if (w_rmw_rd) begin
            r_merge <= w_merged;
            r_state <= ST_RMW_WRITE;
          end
        end
        ST_RMW_WRITE: r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
